// File: rtl/rd_drain_pkg.sv
// Shared types, defaults and pointer helper for the read-side drain stage.
package rd_drain_pkg;

  localparam int unsigned DRAIN_DEPTH_DEFAULT = 2;
  localparam int unsigned DRAIN_DEPTH_MAX     = 4;
  localparam int unsigned DRAIN_PTR_W         = 2;

  typedef logic [2:0]             drain_cnt_t;
  typedef logic [DRAIN_PTR_W-1:0] drain_ptr_t;

  // Modulo-depth pointer increment; wraps from depth-1 back to 0.
  function automatic drain_ptr_t ptr_inc(input drain_ptr_t ptr, input int unsigned depth);
    if (32'(ptr) == depth - 32'd1) begin
      return '0;
    end
    return ptr + drain_ptr_t'(1);
  endfunction

endpackage

// File: rtl/drain_buf.sv
// DEPTH-entry register buffer with write/read pointers; read data is the head entry.
module drain_buf
  import rd_drain_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = DRAIN_DEPTH_DEFAULT
) (
  input  logic              rclk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  output logic [DATA_W-1:0] rd
);

  // Storage is sized for the largest legal depth so the pointer indexes it exactly.
  logic [DATA_W-1:0] mem [DRAIN_DEPTH_MAX];
  drain_ptr_t        wptr;
  drain_ptr_t        rptr;

  always_ff @(posedge rclk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      mem  <= '{default: '0};
    end else begin
      if (we) begin
        mem[wptr] <= wd;
        wptr      <= ptr_inc(wptr, DEPTH);
      end
      if (re) begin
        rptr <= ptr_inc(rptr, DEPTH);
      end
    end
  end

  assign rd = mem[rptr];

endmodule

// File: rtl/rd_drain.sv
// Read-side drain: pops the async FIFO under credit control and streams words out via drain_buf.
module rd_drain
  import rd_drain_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = DRAIN_DEPTH_DEFAULT
) (
  input  logic              rclk,
  input  logic              reset,
  input  logic              empty,
  output logic              pop,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       drained
);

  localparam drain_cnt_t DEPTH_C = drain_cnt_t'(DEPTH);

  drain_cnt_t cnt;
  drain_cnt_t level;
  logic       inflight;
  logic       deq;

  assign out_valid = (cnt != '0);
  assign deq       = out_valid & out_ready;

  // Occupancy after this edge counting the in-flight word; deq implies cnt >= 1, so no underflow.
  assign level = cnt + drain_cnt_t'(inflight) - drain_cnt_t'(deq);
  assign pop   = !reset && !empty && (level < DEPTH_C);

  always_ff @(posedge rclk) begin
    if (reset) begin
      cnt      <= '0;
      inflight <= 1'b0;
      drained  <= '0;
    end else begin
      cnt      <= level;
      inflight <= pop;
      if (deq) begin
        drained <= drained + 16'd1;
      end
    end
  end

  drain_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .rclk  (rclk),
    .reset (reset),
    .we    (inflight),
    .wd    (rdata),
    .re    (deq),
    .rd    (out_data)
  );

  // Every popped word must already own a buffer slot.
  a_credit: assert property (@(posedge rclk) disable iff (reset)
    (32'(cnt) + 32'(inflight)) <= DEPTH);

  a_hold: assert property (@(posedge rclk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule
